// File: rtl/mcp_controller_if.sv
// Control, decode and memory-handshake bundle between the RV32I multi-cycle sequencer
// and its datapath/memory. master = sequencer side, slave = datapath/memory side.
interface mcp_controller_if;
    logic [31:0] instr_i;
    logic        br_taken_i;
    logic        mem_ready_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        addr_sel_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        pc_sel_o;
    logic [2:0]  imm_sel_o;
    logic        a_sel_o;
    logic        b_sel_o;
    logic [3:0]  alu_op_o;
    logic        reg_write_o;
    logic [1:0]  wb_sel_o;
    logic        halted_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] instret_cnt_o;

    modport master (
        input  instr_i, br_taken_i, mem_ready_i,
        output mem_req_o, mem_we_o, addr_sel_o, ir_write_o, pc_write_o, pc_sel_o,
               imm_sel_o, a_sel_o, b_sel_o, alu_op_o, reg_write_o, wb_sel_o,
               halted_o, cycle_cnt_o, instret_cnt_o
    );

    modport slave (
        output instr_i, br_taken_i, mem_ready_i,
        input  mem_req_o, mem_we_o, addr_sel_o, ir_write_o, pc_write_o, pc_sel_o,
               imm_sel_o, a_sel_o, b_sel_o, alu_op_o, reg_write_o, wb_sel_o,
               halted_o, cycle_cnt_o, instret_cnt_o
    );
endinterface

// File: rtl/mcp_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port.
// Optional performance counters are built when MCP_PERF_CNT_EN is defined.
module mcp_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input logic             clk_i,
    input logic             rst_n_i,
    mcp_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    state_t state_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [4:0] rd;
    logic       unused_instr_bits;

    assign opcode   = bus.instr_i[6:0];
    assign rd       = bus.instr_i[11:7];
    assign funct3   = bus.instr_i[14:12];
    assign funct7_5 = bus.instr_i[30];
    assign unused_instr_bits = ^{bus.instr_i[31], bus.instr_i[29:15]};

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic legal, writes_rd;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    // SYSTEM (ECALL/EBREAK) is not in the set, so it falls out as illegal here
    assign legal     = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
    assign writes_rd = is_r | is_i | is_load | is_jal | is_jalr | is_lui | is_auipc;

    logic [2:0] imm_sel_dec;
    logic       a_sel_dec, b_sel_dec;
    logic [3:0] alu_op_dec;
    logic [1:0] wb_sel_dec;

    always_comb begin
        imm_sel_dec = 3'd0;
        if (is_store)                imm_sel_dec = 3'd1;
        else if (is_branch)          imm_sel_dec = 3'd2;
        else if (is_lui || is_auipc) imm_sel_dec = 3'd3;
        else if (is_jal)             imm_sel_dec = 3'd4;

        a_sel_dec  = is_branch | is_jal | is_auipc;
        b_sel_dec  = ~is_r;
        wb_sel_dec = is_load ? 2'd1 : ((is_jal | is_jalr) ? 2'd2 : 2'd0);

        alu_op_dec = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'd0: alu_op_dec = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                3'd1: alu_op_dec = ALU_SLL;
                3'd2: alu_op_dec = ALU_SLT;
                3'd3: alu_op_dec = ALU_SLTU;
                3'd4: alu_op_dec = ALU_XOR;
                3'd5: alu_op_dec = funct7_5 ? ALU_SRA : ALU_SRL;
                3'd6: alu_op_dec = ALU_OR;
                default: alu_op_dec = ALU_AND;
            endcase
        end else if (is_lui) begin
            alu_op_dec = ALU_PASSB;
        end
    end

    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel;
    logic [2:0] imm_sel;
    logic       a_sel, b_sel, reg_write, halted;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;

    // Illegal opcodes decode to no flags, so a NOP in WB gets pc_sel=0 and no reg_write
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        imm_sel   = 3'd0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        halted    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = bus.mem_ready_i;
            end
            S_DECODE: imm_sel = imm_sel_dec;
            S_EXEC: begin
                imm_sel = imm_sel_dec;
                a_sel   = a_sel_dec;
                b_sel   = b_sel_dec;
                alu_op  = alu_op_dec;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                imm_sel  = imm_sel_dec;
                pc_write = is_store & bus.mem_ready_i;
            end
            S_WB: begin
                imm_sel   = imm_sel_dec;
                wb_sel    = wb_sel_dec;
                pc_write  = 1'b1;
                pc_sel    = is_jal | is_jalr | (is_branch & bus.br_taken_i);
                reg_write = writes_rd & (rd != 5'd0);
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  state_reg <= S_FETCH;
                S_FETCH: if (bus.mem_ready_i) state_reg <= S_DECODE;
                S_DECODE: begin
                    if (legal)                state_reg <= S_EXEC;
                    else if (HALT_ON_ILLEGAL) state_reg <= S_HALT;
                    else                      state_reg <= S_WB;
                end
                S_EXEC:  state_reg <= (is_load || is_store) ? S_MEM : S_WB;
                S_MEM: begin
                    if (bus.mem_ready_i) state_reg <= is_store ? S_FETCH : S_WB;
                end
                S_WB:    state_reg <= S_FETCH;
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.addr_sel_o  = addr_sel;
    assign bus.ir_write_o  = ir_write;
    assign bus.pc_write_o  = pc_write;
    assign bus.pc_sel_o    = pc_sel;
    assign bus.imm_sel_o   = imm_sel;
    assign bus.a_sel_o     = a_sel;
    assign bus.b_sel_o     = b_sel;
    assign bus.alu_op_o    = alu_op;
    assign bus.reg_write_o = reg_write;
    assign bus.wb_sel_o    = wb_sel;
    assign bus.halted_o    = halted;

`ifdef MCP_PERF_CNT_EN
    logic [31:0] cycle_cnt_reg, instret_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (pc_write)
                instret_cnt_reg <= instret_cnt_reg + 32'd1;
        end
    end

    assign bus.cycle_cnt_o   = cycle_cnt_reg;
    assign bus.instret_cnt_o = instret_cnt_reg;
`else
    assign bus.cycle_cnt_o   = '0;
    assign bus.instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mcp_controller.sv
// Directed bench for mcp_controller: one DUT halts on illegal opcodes, the other retires them as NOPs.
module tb_mcp_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] instr;
    logic        br_taken;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

`ifdef MCP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // strobe vector: {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write, halted}
    localparam logic [7:0] ST_NONE     = 8'b0000_0000;
    localparam logic [7:0] ST_F_RDY    = 8'b1001_0000;
    localparam logic [7:0] ST_LD_WAIT  = 8'b1010_0000;
    localparam logic [7:0] ST_ST_RDY   = 8'b1110_1000;
    localparam logic [7:0] ST_WB_RD    = 8'b0000_1010;
    localparam logic [7:0] ST_WB_NORD  = 8'b0000_1000;
    localparam logic [7:0] ST_WB_TAKEN = 8'b0000_1100;
    localparam logic [7:0] ST_WB_JUMP  = 8'b0000_1110;
    localparam logic [7:0] ST_HALT     = 8'b0000_0001;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_SUB   = 32'h4020_81B3;
    localparam logic [31:0] I_SRAI  = 32'h4030_D093;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_NOPX0 = 32'h0000_0013;
    localparam logic [31:0] I_ILL   = 32'h0000_0000;

    mcp_controller_if ifa ();
    mcp_controller_if ifb ();

    assign ifa.instr_i     = instr;
    assign ifa.br_taken_i  = br_taken;
    assign ifa.mem_ready_i = mem_ready;
    assign ifb.instr_i     = instr;
    assign ifb.br_taken_i  = br_taken;
    assign ifb.mem_ready_i = mem_ready;

    mcp_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa.master));
    mcp_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb.master));

    logic [7:0]  st_a, st_b;
    logic [10:0] sel_a, sel_b;
    assign st_a  = {ifa.mem_req_o, ifa.mem_we_o, ifa.addr_sel_o, ifa.ir_write_o,
                    ifa.pc_write_o, ifa.pc_sel_o, ifa.reg_write_o, ifa.halted_o};
    assign st_b  = {ifb.mem_req_o, ifb.mem_we_o, ifb.addr_sel_o, ifb.ir_write_o,
                    ifb.pc_write_o, ifb.pc_sel_o, ifb.reg_write_o, ifb.halted_o};
    assign sel_a = {ifa.imm_sel_o, ifa.a_sel_o, ifa.b_sel_o, ifa.alu_op_o, ifa.wb_sel_o};
    assign sel_b = {ifb.imm_sel_o, ifb.a_sel_o, ifb.b_sel_o, ifb.alu_op_o, ifb.wb_sel_o};

    function automatic logic [10:0] sel(input logic [2:0] imm, input logic a, input logic b,
                                        input logic [3:0] op, input logic [1:0] wb);
        return {imm, a, b, op, wb};
    endfunction

    function automatic logic [31:0] cnt(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic note(input string name);
        $display("insn %-6s instr=%08h cycle_cnt=%0d instret_cnt=%0d",
                 name, instr, ifa.cycle_cnt_o, ifa.instret_cnt_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        instr     = I_NOPX0;
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_strobes_a", 32'(st_a), 32'(ST_NONE));
        chk("rst_strobes_b", 32'(st_b), 32'(ST_NONE));
        chk("rst_sel_a", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b0, A_ADD, 2'd0)));
        chk("rst_cycle", ifa.cycle_cnt_o, 32'd0);
        chk("rst_instret", ifa.instret_cnt_o, 32'd0);

        // ADDI x1,x0,5
        rst_n = 1'b1;
        instr = I_ADDI;
        chk("idle_strobes", 32'(st_a), 32'(ST_NONE));
        tick();
        chk("addi_fetch", 32'(st_a), 32'(ST_F_RDY));
        tick();
        chk("addi_decode", 32'(st_a), 32'(ST_NONE));
        tick();
        chk("addi_exec_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b1, A_ADD, 2'd0)));
        tick();
        chk("addi_wb", 32'(st_a), 32'(ST_WB_RD));
        chk("addi_wb_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b0, A_ADD, 2'd0)));
        chk("addi_wb_cycle", ifa.cycle_cnt_o, cnt(3));
        tick();
        chk("addi_instret", ifa.instret_cnt_o, cnt(1));
        chk("addi_cycle", ifa.cycle_cnt_o, cnt(4));
        note("addi");

        // LW x2,0(x1) with three wait cycles in MEM
        instr = I_LW;
        tick();
        tick();
        chk("lw_exec_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b1, A_ADD, 2'd0)));
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", 32'(st_a), 32'(ST_LD_WAIT));
            tick();
        end
        mem_ready = 1'b1;
        chk("lw_mem_ready", 32'(st_a), 32'(ST_LD_WAIT));
        tick();
        chk("lw_wb", 32'(st_a), 32'(ST_WB_RD));
        chk("lw_wb_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b0, A_ADD, 2'd1)));
        chk("lw_wb_cycle", ifa.cycle_cnt_o, cnt(11));
        tick();
        chk("lw_instret", ifa.instret_cnt_o, cnt(2));
        chk("lw_cycle", ifa.cycle_cnt_o, cnt(12));
        note("lw");

        // SW x2,0(x1): retires out of MEM, never reaches WB
        instr = I_SW;
        tick();
        chk("sw_decode", 32'(st_a), 32'(ST_NONE));
        tick();
        chk("sw_exec_sel", 32'(sel_a), 32'(sel(3'd1, 1'b0, 1'b1, A_ADD, 2'd0)));
        tick();
        chk("sw_mem", 32'(st_a), 32'(ST_ST_RDY));
        chk("sw_mem_sel", 32'(sel_a), 32'(sel(3'd1, 1'b0, 1'b0, A_ADD, 2'd0)));
        tick();
        chk("sw_back_to_fetch", 32'(st_a), 32'(ST_F_RDY));
        chk("sw_cycle", ifa.cycle_cnt_o, cnt(16));
        chk("sw_instret", ifa.instret_cnt_o, cnt(3));
        note("sw");

        // BEQ taken then not taken
        instr    = I_BEQ;
        br_taken = 1'b1;
        tick();
        tick();
        chk("beq_exec_sel", 32'(sel_a), 32'(sel(3'd2, 1'b1, 1'b1, A_ADD, 2'd0)));
        tick();
        chk("beq_t_wb", 32'(st_a), 32'(ST_WB_TAKEN));
        chk("beq_t_wb_sel", 32'(sel_a), 32'(sel(3'd2, 1'b0, 1'b0, A_ADD, 2'd0)));
        tick();
        note("beq_t");
        br_taken = 1'b0;
        tick();
        tick();
        tick();
        chk("beq_nt_wb", 32'(st_a), 32'(ST_WB_NORD));
        chk("beq_nt_wb_sel", 32'(sel_a), 32'(sel(3'd2, 1'b0, 1'b0, A_ADD, 2'd0)));
        tick();
        chk("beq_cycle", ifa.cycle_cnt_o, cnt(24));
        chk("beq_instret", ifa.instret_cnt_o, cnt(5));
        note("beq_nt");

        // SUB x3,x1,x2
        instr = I_SUB;
        tick();
        tick();
        chk("sub_exec_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b0, A_SUB, 2'd0)));
        tick();
        chk("sub_wb", 32'(st_a), 32'(ST_WB_RD));
        tick();
        note("sub");

        // SRAI x1,x1,3
        instr = I_SRAI;
        tick();
        tick();
        chk("srai_exec_sel", 32'(sel_a), 32'(sel(3'd0, 1'b0, 1'b1, A_SRA, 2'd0)));
        tick();
        tick();
        note("srai");

        // JAL x1,+16
        instr = I_JAL;
        tick();
        tick();
        chk("jal_exec_sel", 32'(sel_a), 32'(sel(3'd4, 1'b1, 1'b1, A_ADD, 2'd0)));
        tick();
        chk("jal_wb", 32'(st_a), 32'(ST_WB_JUMP));
        chk("jal_wb_sel", 32'(sel_a), 32'(sel(3'd4, 1'b0, 1'b0, A_ADD, 2'd2)));
        tick();
        note("jal");

        // ADDI x0,x0,0: rd=x0 write suppressed
        instr = I_NOPX0;
        tick();
        tick();
        tick();
        chk("x0_wb", 32'(st_a), 32'(ST_WB_NORD));
        tick();
        chk("x0_cycle", ifa.cycle_cnt_o, cnt(40));
        chk("x0_instret", ifa.instret_cnt_o, cnt(9));
        note("addi0");

        // Illegal opcode: dut_a halts, dut_b retires it as a NOP
        instr = I_ILL;
        tick();
        tick();
        chk("ill_a_halt", 32'(st_a), 32'(ST_HALT));
        chk("ill_b_nop_wb", 32'(st_b), 32'(ST_WB_NORD));
        chk("ill_b_nop_sel", 32'(sel_b), 32'(sel(3'd0, 1'b0, 1'b0, A_ADD, 2'd0)));
        chk("ill_a_cycle", ifa.cycle_cnt_o, cnt(42));
        tick();
        chk("ill_b_fetch", 32'(st_b), 32'(ST_F_RDY));
        chk("ill_b_instret", ifb.instret_cnt_o, cnt(10));
        repeat (3) tick();
        chk("halt_held", 32'(st_a), 32'(ST_HALT));
        chk("halt_cycle_frozen", ifa.cycle_cnt_o, cnt(42));
        chk("halt_instret_frozen", ifa.instret_cnt_o, cnt(9));
        note("illegal");

        // Async reset while a load waits in MEM
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        instr = I_LW;
        chk("rst2_idle", 32'(st_a), 32'(ST_NONE));
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("rst2_mem_wait", 32'(st_a), 32'(ST_LD_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_async_drop_a", 32'(st_a), 32'(ST_NONE));
        chk("rst2_async_drop_b", 32'(st_b), 32'(ST_NONE));
        chk("rst2_cycle_clear", ifa.cycle_cnt_o, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        chk("rst2_release_idle", 32'(st_a), 32'(ST_NONE));
        tick();
        chk("rst2_refetch", 32'(st_a), 32'(ST_F_RDY));
        chk("rst2_idle_frozen", ifa.cycle_cnt_o, 32'd0);
        note("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp_controller.md
Name: mcp_controller

Overview:
Multi-cycle sequencer for an RV32I core. One ALU, one unified memory port and the register file are reused across states. The block decodes the latched instruction register (IR). Each cycle it drives datapath selects and strobes, and it handshakes with a variable-latency memory.

Parameters:
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode retires as NOP (PC+4).

Ports:
clk_i  in  1  clock
rst_n_i  in  1  async active-low reset
instr_i  in  32  IR contents (valid from DECODE until the instruction retires)
br_taken_i  in  1  branch comparator result on registered rs1/rs2 (funct3-resolved by datapath)
mem_ready_i  in  1  memory completes the current request
mem_req_o  out  1  memory request
mem_we_o  out  1  write enable (stores)
addr_sel_o  out  1  0=PC, 1=ALU-out register
ir_write_o  out  1  latch memory read data into IR
pc_write_o  out  1  update PC (instruction retires)
pc_sel_o  out  1  0=PC+4, 1=ALU-out register (datapath clears bit0)
imm_sel_o  out  3  I=0, S=1, B=2, U=3, J=4
a_sel_o  out  1  0=rs1, 1=PC
b_sel_o  out  1  0=rs2, 1=imm
alu_op_o  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
reg_write_o  out  1  register-file write
wb_sel_o  out  2  0=ALU-out, 1=MDR, 2=PC+4
halted_o  out  1  core halted
cycle_cnt_o  out  32  active-cycle counter
instret_cnt_o  out  32  retired-instruction counter

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are combinational from the state and instr_i decode.
- Reset: async entry to IDLE. Every output is 0, counters are 0, and any outstanding request is dropped at once. IDLE moves to FETCH on the first clock after reset release.
- FETCH: mem_req=1, addr_sel=0, we=0. Hold until mem_ready_i=1. On ready: ir_write=1, go to DECODE.
- DECODE: the datapath latches rs1/rs2. An opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, or 1110011 (ECALL/EBREAK), is illegal:
  - HALT_ON_ILLEGAL=1: go to HALT.
  - HALT_ON_ILLEGAL=0: go to WB as NOP (pc_write=1, pc_sel=0, no reg_write).
  - Otherwise go to EXEC.
- EXEC: ALU operation by opcode; the result is latched into the ALU-out register.
  - R/I: funct3/funct7[5] map to alu_op. SUB only for R-type; SRA when funct7[5]=1.
  - Load/Store: rs1+imm (I or S).
  - Branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: rs1+immI.
  - AUIPC: PC+immU.
  - LUI: PASSB with immU.
  - Next state: MEM for load/store, WB otherwise.
- MEM: mem_req=1, addr_sel=1, we=store. Hold until ready.
  - Store: on ready, pc_write=1, pc_sel=0, go to FETCH.
  - Load: on ready, MDR latches, go to WB.
- WB:
  - reg_write=1 when the opcode writes rd and rd!=0. rd=x0 writes are suppressed.
  - wb_sel: ALU ops/LUI/AUIPC=0, load=1, JAL/JALR=2.
  - pc_write=1. pc_sel=1 for JAL/JALR and for a branch with br_taken_i=1; otherwise 0.
  - Next state: FETCH.
- Latency with zero-wait memory (mem_ready_i=1 in the first request cycle): ALU, branch and jump take 4 cycles; load takes 5; store takes 4. Each wait cycle adds 1.
- Handshake: mem_req_o, addr_sel_o and mem_we_o stay stable while mem_req_o=1 and mem_ready_i=0. mem_ready_i is ignored while mem_req_o=0.
- HALT: all strobes are 0 and halted_o=1. Exit only by reset.
- Reset mid-operation: the partial instruction is discarded and no pc_write/reg_write is issued.

Optional Feature:
MCP_PERF_CNT_EN
- Defined: cycle_cnt_o increments on every clock in FETCH/DECODE/EXEC/MEM/WB. instret_cnt_o increments on every cycle with pc_write_o=1. Both wrap 0xFFFFFFFF to 0. Both are frozen in IDLE/HALT.
- Undefined: both outputs are tied to 0 and no counter flops are present.

Test Plan:
- ADDI x1,x0,5 (0x00500093), zero-wait → sequence IDLE, F, D, E, W. In WB: reg_write=1, wb_sel=0, pc_write=1, pc_sel=0. instret=1 (with MCP_PERF_CNT_EN).
- LW x2,0(x1) (0x0000A103), mem_ready_i low 3 cycles in MEM → mem_req=1, addr_sel=1, we=0 held 4 cycles. Then WB with wb_sel=1, reg_write=1. Total 8 cycles.
- SW x2,0(x1) (0x0020A023) → MEM: we=1, imm_sel=1. On ready: pc_write=1 in MEM, no WB state, reg_write never asserted.
- BEQ x1,x2,+8 (0x00208463) → WB: pc_sel=1 with br_taken_i=1, pc_sel=0 with br_taken_i=0. reg_write=0 and imm_sel=2 both times.
- 0x00000000 with HALT_ON_ILLEGAL=1 → HALT after DECODE, halted_o=1, no further mem_req, cycle_cnt frozen. With HALT_ON_ILLEGAL=0 → retires as NOP via WB.
- rst_n_i low while in MEM with mem_req_o=1 → mem_req_o drops without a clock edge, state=IDLE. FETCH restarts one clock after release.
